// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the multi-port register file (optional bypass: REGFILE_BYPASS_EN)
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

    localparam int RF_XLEN     = 32;
    localparam int RF_NREGS    = 32;
    localparam int RF_ZERO_REG = 0;

endpackage

// File: rtl/regfile_clr_seq.sv
// rtl/regfile_clr_seq.sv - post-reset clear sweep sequencer producing zeroing writes and ready
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int NREGS = RF_NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic          ready
);

    rf_state_t     state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;

    // State and sweep index; reset restarts the sweep at entry 1 (x0 is never stored)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            idx_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: step through every entry, leave CLEAR on the edge that clears the last one
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == RF_CLEAR) begin
            idx_d = idx_q + AW'(1);
            if (idx_q == AW'(NREGS - 1)) begin
                state_d = RF_RUN;
            end
        end
    end

    // Outputs are pure decodes of the registered state, so ready cannot glitch on write inputs
    always_comb begin
        clr_we   = (state_q == RF_CLEAR);
        clr_addr = idx_q;
        ready    = (state_q == RF_RUN);
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - NRD-read / 2-write register file with x0 hardwired to zero (optional bypass: REGFILE_BYPASS_EN)
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = RF_XLEN,
    parameter int NREGS = RF_NREGS,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    input  logic                we0,
    input  logic [AW-1:0]       rd0,
    input  logic [XLEN-1:0]     wd0,
    input  logic                we1,
    input  logic [AW-1:0]       rd1,
    input  logic [XLEN-1:0]     wd1,
    output logic                ready
);

    logic          clr_we;
    logic [AW-1:0] clr_addr;

    logic [XLEN-1:0] mem_q [NREGS];
    logic [XLEN-1:0] mem_d [NREGS];
    logic [AW-1:0]   rd_addr [NRD];
    logic [XLEN-1:0] rd_val  [NRD];

    regfile_clr_seq #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (ready)
    );

    // Per-entry next value: sweep zeroing in CLEAR, otherwise load port overrides ALU port on collision
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            mem_d[i] = mem_q[i];
            if (i == RF_ZERO_REG) begin
                mem_d[i] = '0;
            end else if (clr_we && (clr_addr == AW'(i))) begin
                mem_d[i] = '0;
            end else if (ready) begin
                if (we1 && (rd1 == AW'(i))) begin
                    mem_d[i] = wd1;
                end else if (we0 && (rd0 == AW'(i))) begin
                    mem_d[i] = wd0;
                end
            end
        end
    end

    // Array storage; no reset because the sweep rewrites every entry before RUN is reached
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    // Read muxes: zero in CLEAR and for x0, optional same-cycle forwarding of in-flight writes
    always_comb begin
        rs_data = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_addr[k] = rs_addr[k*AW +: AW];
            rd_val[k]  = '0;
            if (ready && (rd_addr[k] != AW'(RF_ZERO_REG))) begin
                rd_val[k] = mem_q[rd_addr[k]];
`ifdef REGFILE_BYPASS_EN
                if (we0 && (rd0 == rd_addr[k])) begin
                    rd_val[k] = wd0;
                end
                if (we1 && (rd1 == rd_addr[k])) begin
                    rd_val[k] = wd1;
                end
`endif
            end
            rs_data[k*XLEN +: XLEN] = rd_val[k];
        end
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file, the successor to the single-write, two-read core register file. It serves the decode stage with `NRD` combinational read ports and accepts two writes per cycle: port 0 from ALU writeback and port 1 from load writeback. Register x0 is hardwired to zero. After reset, a built-in clear sequencer zeroes the array and gates the pipeline with `ready`.

## Interface
- `XLEN`, 32, data width in bits
- `NREGS`, 32, number of architectural registers; a power of two, at least 2
- `NRD`, 2, number of read ports, 1..4
- `AW`, $clog2(NREGS), address width (derived; not overridden)
- `clk`  in  1  single clock, all state updates on the rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `rs_addr`  in  NRD*AW  packed read addresses; port k occupies bits [k*AW +: AW]
- `rs_data`  out  NRD*XLEN  packed read data; port k occupies bits [k*XLEN +: XLEN]
- `we0`  in  1  write enable, port 0 (ALU)
- `rd0`  in  AW  write address, port 0
- `wd0`  in  XLEN  write data, port 0
- `we1`  in  1  write enable, port 1 (load)
- `rd1`  in  AW  write address, port 1
- `wd1`  in  XLEN  write data, port 1
- `ready`  out  1  high once the clear sweep is complete; writes are accepted only while high

## Operation
- Two states:
  - CLEAR: entered asynchronously whenever `rst`=1.
  - RUN: reached when the sweep finishes.
- Reset values:
  - state=CLEAR, `clr_idx`=1, `ready`=0.
  - `rs_data` is all zeros while in CLEAR.
- CLEAR behaviour:
  - On each rising edge with `rst`=0, write 0 to entry `clr_idx`, then increment `clr_idx`.
  - The edge that writes entry NREGS-1 moves the state to RUN.
  - `we0`/`we1` are ignored in CLEAR. The requester holds the pipeline off until `ready`=1.
- RUN, reads:
  - `rs_data[k]` = entry[`rs_addr[k]`], combinational.
  - Address 0 always reads 0.
- RUN, writes:
  - Writes commit on the rising edge.
  - A write whose address is 0 is dropped.
- Write collision: `we0`=`we1`=1 with `rd0`==`rd1`≠0 → port 1 (load) value is stored and port 0 is discarded.
- Independent writes: different nonzero addresses → both commit on the same edge.
- Reset mid-sweep or mid-RUN: return to CLEAR immediately and restart the sweep at entry 1. Any partially applied write is discarded.
- Out-of-range addresses cannot occur because NREGS is a power of two. No wrap logic is needed beyond the AW-bit counter.

## Timing
- Read latency is 0 cycles, combinational from `rs_addr`.
- Write-to-read latency:
  - 1 edge without bypass.
  - 0 cycles with bypass (see Configuration).
- `ready` rises exactly NREGS-1 rising edges after `rst` falls: 31 edges for the defaults. It then stays high until the next `rst`.
- `ready` is a registered state decode; it never glitches combinationally with the write inputs.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - In RUN, a read whose address matches an active nonzero write address returns that write data in the same cycle.
  - If both write ports match, port 1 data is returned.
  - Address 0 still reads 0.
  - Bypass is inactive in CLEAR.
- `REGFILE_BYPASS_EN` undefined: reads always return the stored value, so the old data is seen in the write cycle.

## Structure
- `regfile_pkg` holds:
  - the state typedef `rf_state_t` {RF_CLEAR, RF_RUN};
  - the default constants `RF_XLEN`=32 and `RF_NREGS`=32;
  - the `RF_ZERO_REG`=0 address constant.
- One sub-module, `regfile_clr_seq`. It contains the state flop and `clr_idx` counter, and outputs `clr_we`, `clr_addr` and `ready`.
- The array, write arbitration, read muxes and bypass stay in `regfile_mp`.

## Test plan
- Reset sweep: pulse `rst` with `we0`=1 held, then count edges → `ready`=0 for 31 edges and 1 on the 31st. Every address then reads 0, and the held write is not stored.
- Basic RW: write 0xDEADBEEF to x5 via port 0 and 0x12345678 to x9 via port 1 on the same edge → next cycle x5 reads 0xDEADBEEF and x9 reads 0x12345678.
- Collision: both ports write x7, port 0 = 0x1111 and port 1 = 0x2222 → x7 reads 0x2222.
- x0: write 0xFFFFFFFF to x0 on both ports → x0 reads 0 on all read ports.
- Bypass: with `rs_addr[0]`=x3 held, write 0xABCD to x3 (previously 0x0):
  - with `REGFILE_BYPASS_EN`, `rs_data[0`]=0xABCD in the write cycle;
  - without it, 0x0 in the write cycle and 0xABCD after the edge.
- Mid-run reset: after loading x1..x4, assert `rst` for one cycle → `ready` drops asynchronously and re-rises after 31 edges, with x1..x4 reading 0.
